song_reader: RTL and testbench

- Sequencer directly downstream of song_rom. Walks one 32-entry song region of the ROM from entry 0 to entry 31.
- Each note entry is dispatched as a one-cycle note event to a round-robin voice (note player).
- Each advance entry stalls the walk for the encoded number of beat pulses.
- Sits between song_rom and the note_player bank; beat comes from the shared beat generator.

---
 rtl/song_reader.sv | 158 +++++++++++++++
 tb/tb_song_reader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/song_reader.sv
//------------------------------------------------------------------------------
// song_reader: walks one song region of song_rom, dispatching note entries to
// round-robin voices and stalling on advance entries for a number of beats.
//------------------------------------------------------------------------------
`default_nettype none

module song_reader #(
    parameter int ADDR_WIDTH = 7,
    parameter int SONG_BITS  = 2,
    parameter int NUM_VOICES = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  play,
    input  logic [SONG_BITS-1:0]  song,
    input  logic                  beat,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [15:0]           rom_data,
    output logic                  new_note,
    output logic [5:0]            note,
    output logic [5:0]            duration,
    output logic [1:0]            voice,
    output logic                  song_done
);

    localparam int IDX_BITS = ADDR_WIDTH - SONG_BITS;
    localparam logic [IDX_BITS-1:0] LAST_IDX = '1;
    localparam logic [1:0] LAST_VOICE = 2'(NUM_VOICES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_WAIT   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                state, state_n;
    logic [IDX_BITS-1:0]   entry_idx, entry_idx_n;
    logic [SONG_BITS-1:0]  song_latched, song_latched_n;
    logic [1:0]            voice_ptr, voice_ptr_n;
    logic [1:0]            voice_n;
    logic                  new_note_n;
    logic [5:0]            note_n, duration_n;
    logic                  song_done_n;
    logic [5:0]            wait_cnt, wait_cnt_n;
    logic                  advance;

    // Low bits of a note entry are padding.
    logic unused_rom_bits;
    assign unused_rom_bits = ^rom_data[2:0];

    assign rom_addr = {song_latched, entry_idx};

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            entry_idx    <= '0;
            song_latched <= '0;
            voice_ptr    <= 2'd0;
            voice        <= 2'd0;
            new_note     <= 1'b0;
            note         <= 6'd0;
            duration     <= 6'd0;
            song_done    <= 1'b0;
            wait_cnt     <= 6'd0;
        end else begin
            state        <= state_n;
            entry_idx    <= entry_idx_n;
            song_latched <= song_latched_n;
            voice_ptr    <= voice_ptr_n;
            voice        <= voice_n;
            new_note     <= new_note_n;
            note         <= note_n;
            duration     <= duration_n;
            song_done    <= song_done_n;
            wait_cnt     <= wait_cnt_n;
        end
    end

    always_comb begin
        state_n        = state;
        entry_idx_n    = entry_idx;
        song_latched_n = song_latched;
        voice_ptr_n    = voice_ptr;
        voice_n        = voice;
        new_note_n     = 1'b0;
        note_n         = note;
        duration_n     = duration;
        song_done_n    = 1'b0;
        wait_cnt_n     = wait_cnt;
        advance        = 1'b0;

        case (state)
            S_IDLE: begin
                if (play) begin
                    song_latched_n = song;
                    entry_idx_n    = '0;
                    voice_ptr_n    = 2'd0;
                    voice_n        = 2'd0;
                    state_n        = S_FETCH;
                end
            end
            S_FETCH: begin
                if (play) begin
                    state_n = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!rom_data[15]) begin
                    note_n      = rom_data[14:9];
                    duration_n  = rom_data[8:3];
                    voice_n     = voice_ptr;
                    new_note_n  = 1'b1;
                    voice_ptr_n = (voice_ptr == LAST_VOICE) ? 2'd0 : voice_ptr + 2'd1;
                    advance     = 1'b1;
                end else if (rom_data[14:9] == 6'd0) begin
                    advance = 1'b1;
                end else begin
                    wait_cnt_n = rom_data[14:9];
                    state_n    = S_WAIT;
                end
            end
            S_WAIT: begin
                // Beats arriving while paused are dropped, not deferred.
                if (beat && play) begin
                    if (wait_cnt == 6'd1) begin
                        wait_cnt_n = 6'd0;
                        advance    = 1'b1;
                    end else begin
                        wait_cnt_n = wait_cnt - 6'd1;
                    end
                end
            end
            S_DONE: begin
                if (!play) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        if (advance) begin
            if (entry_idx == LAST_IDX) begin
                state_n     = S_DONE;
                song_done_n = 1'b1;
            end else begin
                entry_idx_n = entry_idx + IDX_BITS'(1);
                state_n     = S_FETCH;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_song_reader.sv
//------------------------------------------------------------------------------
// tb_song_reader: directed bench with a behavioural song_rom beside the DUT.
//------------------------------------------------------------------------------
`default_nettype none

module tb_song_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        play;
    logic [1:0]  song;
    logic        beat;
    logic [6:0]  rom_addr;
    logic [15:0] rom_data;
    logic        new_note;
    logic [5:0]  note;
    logic [5:0]  duration;
    logic [1:0]  voice;
    logic        song_done;

    logic [15:0] rom [128];
    int checks = 0;
    int errors = 0;

    song_reader #(.ADDR_WIDTH(7), .SONG_BITS(2), .NUM_VOICES(3)) dut (
        .clk(clk), .reset(reset), .play(play), .song(song), .beat(beat),
        .rom_addr(rom_addr), .rom_data(rom_data), .new_note(new_note),
        .note(note), .duration(duration), .voice(voice), .song_done(song_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    function automatic logic [15:0] note_e(input int n, input int d);
        return {1'b0, 6'(n), 6'(d), 3'b000};
    endfunction

    function automatic logic [15:0] adv_e(input int w);
        return {1'b1, 6'(w), 9'd0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_beat();
        beat = 1'b1;
        tick();
        beat = 1'b0;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        int dn_seen;
        int nn_seen;

        for (int i = 0; i < 128; i++) rom[i] = adv_e(0);
        rom[0]  = note_e(40, 48);
        rom[1]  = adv_e(12);
        rom[2]  = note_e(44, 36);
        rom[3]  = adv_e(12);
        rom[4]  = note_e(47, 24);
        rom[5]  = adv_e(24);
        rom[32] = note_e(40, 48);
        rom[64] = note_e(52, 48);

        reset = 1'b1; play = 1'b0; song = 2'd0; beat = 1'b0;
        tick(); tick();
        chk("reset_new_note", new_note, 0);
        chk("reset_note", note, 0);
        chk("reset_duration", duration, 0);
        chk("reset_voice", voice, 0);
        chk("reset_song_done", song_done, 0);
        chk("reset_rom_addr", rom_addr, 0);

        // Song 0: three notes separated by advance entries.
        reset = 1'b0; play = 1'b1;
        tick();                       // FETCH idx0
        chk("s0_fetch_addr", rom_addr, 0);
        tick();                       // DECODE idx0
        chk("s0_no_early_note", new_note, 0);
        tick();                       // FETCH idx1, note pulse
        chk("n0_pulse", new_note, 1);
        chk("n0_note", note, 40);
        chk("n0_dur", duration, 48);
        chk("n0_voice", voice, 0);
        tick();                       // DECODE idx1
        chk("n0_pulse_one_cycle", new_note, 0);
        tick();                       // WAIT 12
        for (int i = 0; i < 11; i++) pulse_beat();
        chk("w1_hold_11_beats", rom_addr, 1);
        pulse_beat();
        chk("w1_release_12th", rom_addr, 2);
        tick(); tick();
        chk("n1_pulse", new_note, 1);
        chk("n1_note", note, 44);
        chk("n1_dur", duration, 36);
        chk("n1_voice", voice, 1);
        tick(); tick();               // WAIT 12
        chk("n1_hold_note", note, 44);
        for (int i = 0; i < 12; i++) pulse_beat();
        chk("w3_release", rom_addr, 4);
        tick(); tick();
        chk("n2_pulse", new_note, 1);
        chk("n2_note", note, 47);
        chk("n2_dur", duration, 24);
        chk("n2_voice", voice, 2);
        tick(); tick();               // WAIT 24
        for (int i = 0; i < 19; i++) pulse_beat();
        song = 2'd3;
        play = 1'b0;
        for (int i = 0; i < 10; i++) pulse_beat();
        chk("pause_hold_addr", rom_addr, 5);
        play = 1'b1;
        for (int i = 0; i < 4; i++) pulse_beat();
        chk("resume_4_beats", rom_addr, 5);
        pulse_beat();
        chk("resume_5th_beat", rom_addr, 6);

        // Entries 6..31 are zero waits: two cycles each.
        dn_seen = 0;
        nn_seen = 0;
        for (int i = 0; i < 51; i++) begin
            tick();
            dn_seen += int'(song_done);
            nn_seen += int'(new_note);
        end
        chk("no_early_done", dn_seen, 0);
        chk("no_note_in_zero_waits", nn_seen, 0);
        tick();
        chk("done_pulse", song_done, 1);
        chk("done_addr", rom_addr, 31);
        tick();
        chk("done_one_cycle", song_done, 0);
        tick(); tick();
        chk("no_restart_addr", rom_addr, 31);
        chk("no_restart_note", new_note, 0);

        // Restart with song 1 after play falls.
        play = 1'b0;
        tick();
        song = 2'd1; play = 1'b1;
        tick();
        chk("s1_addr", rom_addr, 32);
        tick(); tick();
        chk("s1_pulse", new_note, 1);
        chk("s1_note", note, 40);
        chk("s1_voice", voice, 0);

        // Song 2 address progression.
        reset = 1'b1; play = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        song = 2'd2; play = 1'b1;
        tick();
        chk("s2_addr0", rom_addr, 64);
        tick(); tick();
        chk("s2_pulse", new_note, 1);
        chk("s2_note", note, 52);
        chk("s2_dur", duration, 48);
        chk("s2_voice", voice, 0);
        chk("s2_addr1", rom_addr, 65);
        for (int i = 2; i < 32; i++) begin
            tick(); tick();
            chk("s2_addr_walk", rom_addr, 64 + i);
        end
        tick(); tick();
        chk("s2_done", song_done, 1);

        // Reset while waiting.
        play = 1'b0;
        tick();
        song = 2'd0; play = 1'b1;
        tick(); tick(); tick(); tick(); tick();   // WAIT on idx1
        chk("pre_reset_addr", rom_addr, 1);
        reset = 1'b1;
        tick();
        chk("rst_wait_new_note", new_note, 0);
        chk("rst_wait_note", note, 0);
        chk("rst_wait_dur", duration, 0);
        chk("rst_wait_voice", voice, 0);
        chk("rst_wait_done", song_done, 0);
        chk("rst_wait_addr", rom_addr, 0);

        // Reset during a note decode cancels the pulse.
        reset = 1'b0;
        tick();                       // FETCH idx0
        tick();                       // DECODE idx0
        reset = 1'b1;
        tick();
        chk("rst_cancel_pulse", new_note, 0);
        chk("rst_cancel_note", note, 0);
        reset = 1'b0; play = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
